// File: rtl/guess_entry_ctrl.sv
// rtl/guess_entry_ctrl.sv - guess entry, submit handshake and history playback sequencer (optional NO_DUPLICATE_EN)
module guess_entry_ctrl #(
    parameter int NUM_COLORS  = 6,
    parameter int MAX_GUESSES = 8,
    parameter int HIST_DWELL  = 50,
    parameter int HIST_AW     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_color,
    input  logic               btn_submit,
    input  logic               btn_history,
    input  logic               guess_ack,
    input  logic               game_won,
    output logic               blink_enable,
    output logic [1:0]         blink_led,
    output logic [2:0]         guess_rgb0,
    output logic [2:0]         guess_rgb1,
    output logic [2:0]         guess_rgb2,
    output logic [2:0]         guess_rgb3,
    output logic               guess_valid,
    output logic [11:0]        guess_word,
    output logic [HIST_AW-1:0] hist_addr,
    output logic [4:0]         guess_count,
    output logic               reject,
    output logic               locked
);

    localparam int DW = (HIST_DWELL > 1) ? $clog2(HIST_DWELL) : 1;

    localparam logic [1:0] S_EDIT     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_HIST     = 2'd2;
    localparam logic [1:0] S_LOCKED   = 2'd3;

    localparam logic [2:0]    LAST_COLOR = 3'(NUM_COLORS);
    localparam logic [4:0]    MAX_CNT    = 5'(MAX_GUESSES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(HIST_DWELL - 1);

    logic [1:0]    state;
    logic [2:0]    slot [4];
    logic [DW-1:0] dwell;

    logic               any_unset;
    logic               dup_found;
    logic               submit_ok;
    logic [4:0]         next_count;
    logic [HIST_AW-1:0] last_entry;

    assign guess_rgb0 = slot[0];
    assign guess_rgb1 = slot[1];
    assign guess_rgb2 = slot[2];
    assign guess_rgb3 = slot[3];

    assign any_unset = (slot[0] == 3'd0) || (slot[1] == 3'd0) ||
                       (slot[2] == 3'd0) || (slot[3] == 3'd0);

`ifdef NO_DUPLICATE_EN
    // Unset slots are already caught by any_unset, so plain equality suffices here.
    assign dup_found = (slot[0] == slot[1]) || (slot[0] == slot[2]) ||
                       (slot[0] == slot[3]) || (slot[1] == slot[2]) ||
                       (slot[1] == slot[3]) || (slot[2] == slot[3]);
`else
    assign dup_found = 1'b0;
`endif

    assign submit_ok  = !any_unset && !dup_found;
    assign next_count = (guess_count >= MAX_CNT) ? MAX_CNT : guess_count + 5'd1;
    assign last_entry = HIST_AW'(guess_count - 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_EDIT;
            for (int i = 0; i < 4; i++) slot[i] <= 3'd0;
            blink_led    <= 2'd0;
            blink_enable <= 1'b1;
            guess_valid  <= 1'b0;
            guess_word   <= 12'd0;
            hist_addr    <= '0;
            guess_count  <= 5'd0;
            reject       <= 1'b0;
            locked       <= 1'b0;
            dwell        <= '0;
        end else begin
            reject <= 1'b0;
            case (state)
                S_EDIT: begin
                    if (btn_submit) begin
                        if (submit_ok) begin
                            guess_word  <= {slot[3], slot[2], slot[1], slot[0]};
                            guess_valid <= 1'b1;
                            state       <= S_WAIT_ACK;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (btn_history) begin
                        if (guess_count == 5'd0) begin
                            reject <= 1'b1;
                        end else begin
                            hist_addr    <= '0;
                            dwell        <= '0;
                            blink_enable <= 1'b0;
                            state        <= S_HIST;
                        end
                    end else if (btn_color) begin
                        slot[blink_led] <= (slot[blink_led] == LAST_COLOR) ? 3'd1
                                                                           : slot[blink_led] + 3'd1;
                    end else if (btn_right) begin
                        blink_led <= blink_led + 2'd1;
                    end else if (btn_left) begin
                        blink_led <= blink_led - 2'd1;
                    end
                end

                S_WAIT_ACK: begin
                    if (guess_ack) begin
                        guess_valid <= 1'b0;
                        guess_count <= next_count;
                        for (int i = 0; i < 4; i++) slot[i] <= 3'd0;
                        blink_led   <= 2'd0;
                        if (game_won || (next_count == MAX_CNT)) begin
                            state        <= S_LOCKED;
                            locked       <= 1'b1;
                            blink_enable <= 1'b0;
                            hist_addr    <= HIST_AW'(next_count - 5'd1);
                        end else begin
                            state <= S_EDIT;
                        end
                    end
                end

                S_HIST: begin
                    if (btn_history) begin
                        state        <= S_EDIT;
                        blink_enable <= 1'b1;
                        hist_addr    <= '0;
                        dwell        <= '0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (hist_addr == last_entry) begin
                            state        <= S_EDIT;
                            blink_enable <= 1'b1;
                            hist_addr    <= '0;
                        end else begin
                            hist_addr <= hist_addr + 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb/tb_guess_entry_ctrl.sv - scoreboard bench for guess_entry_ctrl with a behavioural model
module tb_guess_entry_ctrl;

    localparam int NC = 6;
    localparam int MG = 4;
    localparam int HD = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
    logic btn_submit = 1'b0, btn_history = 1'b0;
    logic guess_ack = 1'b0, game_won = 1'b0;
    logic          blink_enable;
    logic [1:0]    blink_led;
    logic [2:0]    guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic          guess_valid;
    logic [11:0]   guess_word;
    logic [AW-1:0] hist_addr;
    logic [4:0]    guess_count;
    logic          reject;
    logic          locked;

    always #5 clk = ~clk;

    guess_entry_ctrl #(
        .NUM_COLORS(NC), .MAX_GUESSES(MG), .HIST_DWELL(HD), .HIST_AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
        .btn_submit(btn_submit), .btn_history(btn_history),
        .guess_ack(guess_ack), .game_won(game_won),
        .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
        .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .guess_valid(guess_valid), .guess_word(guess_word),
        .hist_addr(hist_addr), .guess_count(guess_count),
        .reject(reject), .locked(locked)
    );

    typedef struct {
        int be, bl, r0, r1, r2, r3, gv, gw, ha, gc, rj, lk;
    } snap_t;

    typedef enum {M_EDIT, M_WAIT, M_HIST, M_LOCK} mode_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    mode_t mode;
    int    slot[4];
    int    cursor, count, word, elapsed, rej;

    function automatic snap_t model_snap();
        snap_t s;
        s.be = (mode == M_EDIT || mode == M_WAIT) ? 1 : 0;
        s.bl = cursor;
        s.r0 = slot[0]; s.r1 = slot[1]; s.r2 = slot[2]; s.r3 = slot[3];
        s.gv = (mode == M_WAIT) ? 1 : 0;
        s.gw = word;
        s.ha = (mode == M_HIST) ? elapsed / HD : (mode == M_LOCK) ? count - 1 : 0;
        s.gc = count;
        s.rj = rej;
        s.lk = (mode == M_LOCK) ? 1 : 0;
        return s;
    endfunction

    task automatic model_reset();
        mode = M_EDIT;
        for (int i = 0; i < 4; i++) slot[i] = 0;
        cursor = 0; count = 0; word = 0; elapsed = 0; rej = 0;
    endtask

    function automatic bit guess_acceptable();
        bit ok = 1;
        for (int i = 0; i < 4; i++) if (slot[i] == 0) ok = 0;
`ifdef NO_DUPLICATE_EN
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (slot[i] == slot[j]) ok = 0;
`endif
        return ok;
    endfunction

    task automatic model_step(input bit l, r, c, s, h, ack, won);
        rej = 0;
        case (mode)
            M_EDIT: begin
                if (s) begin
                    if (guess_acceptable()) begin
                        word = slot[0] + slot[1] * 8 + slot[2] * 64 + slot[3] * 512;
                        mode = M_WAIT;
                    end else rej = 1;
                end else if (h) begin
                    if (count == 0) rej = 1;
                    else begin mode = M_HIST; elapsed = 0; end
                end else if (c) slot[cursor] = slot[cursor] % NC + 1;
                else if (r) cursor = (cursor + 1) % 4;
                else if (l) cursor = (cursor + 3) % 4;
            end
            M_WAIT: begin
                if (ack) begin
                    count = (count + 1 > MG) ? MG : count + 1;
                    for (int i = 0; i < 4; i++) slot[i] = 0;
                    cursor = 0;
                    mode = (won || count == MG) ? M_LOCK : M_EDIT;
                end
            end
            M_HIST: begin
                if (h) mode = M_EDIT;
                else begin
                    elapsed++;
                    if (elapsed == count * HD) mode = M_EDIT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input bit rst, l, r, c, s, h, ack, won);
        @(negedge clk);
        rst_n = !rst;
        btn_left = l; btn_right = r; btn_color = c;
        btn_submit = s; btn_history = h;
        guess_ack = ack; game_won = won;
        if (rst) model_reset();
        else model_step(l, r, c, s, h, ack, won);
        exp_q.push_back(model_snap());
    endtask

    task automatic press(input bit l, r, c, s, h);
        drive(0, l, r, c, s, h, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) press(0, 0, 0, 0, 0);
    endtask

    task automatic colour_n(input int n);
        repeat (n) press(0, 0, 1, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            chk("blink_enable", int'(blink_enable), e.be);
            chk("blink_led",    int'(blink_led),    e.bl);
            chk("guess_rgb0",   int'(guess_rgb0),   e.r0);
            chk("guess_rgb1",   int'(guess_rgb1),   e.r1);
            chk("guess_rgb2",   int'(guess_rgb2),   e.r2);
            chk("guess_rgb3",   int'(guess_rgb3),   e.r3);
            chk("guess_valid",  int'(guess_valid),  e.gv);
            chk("guess_word",   int'(guess_word),   e.gw);
            chk("hist_addr",    int'(hist_addr),    e.ha);
            chk("guess_count",  int'(guess_count),  e.gc);
            chk("reject",       int'(reject),       e.rj);
            chk("locked",       int'(locked),       e.lk);
        end
    end

    initial begin
        int lock_cycles;
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        colour_n(7);
        colour_n(0);
        press(0, 1, 0, 0, 0); colour_n(1);
        press(0, 1, 0, 0, 0); colour_n(3);
        press(0, 0, 0, 1, 0);
        idle(1);
        press(0, 1, 0, 0, 0); colour_n(4);
        press(0, 0, 0, 1, 0);
        idle(5);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        repeat (2) begin
            for (int k = 0; k < 4; k++) begin
                colour_n(k + 2);
                press(0, 1, 0, 0, 0);
            end
            press(0, 0, 0, 1, 0);
            idle(2);
            drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        press(0, 0, 0, 0, 1);
        idle(14);
        press(0, 0, 0, 0, 1);
        idle(3);
        press(0, 0, 0, 0, 1);
        idle(2);
        for (int k = 0; k < 4; k++) begin
            colour_n(k + 1);
            press(0, 1, 0, 0, 0);
        end
        press(0, 0, 1, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        press(1, 1, 1, 1, 1);
        press(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        colour_n(2); press(0, 1, 0, 0, 0);
        colour_n(5); press(0, 1, 0, 0, 0);
        colour_n(2); press(0, 1, 0, 0, 0);
        colour_n(1);
        press(0, 0, 0, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        lock_cycles = 0;
        for (int n = 0; n < 15000; n++) begin
            bit rst;
            lock_cycles = (mode == M_LOCK) ? lock_cycles + 1 : 0;
            rst = (lock_cycles > 10) || ($urandom_range(1999) == 0);
            drive(rst,
                  $urandom_range(99) < 10, $urandom_range(99) < 18,
                  $urandom_range(99) < 28, $urandom_range(99) < 7,
                  $urandom_range(99) < 3,
                  $urandom_range(99) < 30, $urandom_range(99) < 8);
        end
        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
